// File: rtl/tmds_pkg.sv
// ----------------------------------------------------------------------------
// tmds_pkg
// Shared definitions for the TMDS channel receiver: the four 10-bit control
// tokens (written MSB..LSB, bit 0 is the first bit on the wire) and the
// alignment FSM state type.
// ----------------------------------------------------------------------------
package tmds_pkg;

    localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } rx_state_t;

endpackage

// File: rtl/tmds_symbol_decode.sv
// ----------------------------------------------------------------------------
// tmds_symbol_decode
// Purely combinational 10b -> 8b / control decoder for one aligned symbol.
//
// Ports
//   aligned_word : in  [9:0] symbol already aligned to the 10-bit boundary
//   is_ctrl      : out       1 when aligned_word is one of the control tokens
//   ctrl         : out [1:0] control code {c1,c0} (0 when not a token)
//   data         : out [7:0] video byte decoded from aligned_word
// ----------------------------------------------------------------------------
module tmds_symbol_decode
    import tmds_pkg::*;
(
    input  logic [9:0] aligned_word,
    output logic       is_ctrl,
    output logic [1:0] ctrl,
    output logic [7:0] data
);

    // Bit 9 flags that the transmitter inverted the payload to balance DC.
    logic [7:0] w_q;
    assign w_q = aligned_word[9] ? ~aligned_word[7:0] : aligned_word[7:0];

    // Bit 8 selects whether the chain was built with XOR (1) or XNOR (0).
    always_comb begin
        data    = 8'd0;
        data[0] = w_q[0];
        for (int i = 1; i < 8; i++) begin
            data[i] = aligned_word[8] ? (w_q[i] ^ w_q[i-1]) : ~(w_q[i] ^ w_q[i-1]);
        end
    end

    always_comb begin
        is_ctrl = 1'b1;
        ctrl    = 2'b00;
        case (aligned_word)
            CTRL_TOKEN_00: ctrl = 2'b00;
            CTRL_TOKEN_01: ctrl = 2'b01;
            CTRL_TOKEN_10: ctrl = 2'b10;
            CTRL_TOKEN_11: ctrl = 2'b11;
            default:       is_ctrl = 1'b0;
        endcase
    end

endmodule

// File: rtl/tmds_channel_rx.sv
// ----------------------------------------------------------------------------
// tmds_channel_rx
// One TMDS channel receiver: finds the 10-bit symbol boundary in a stream of
// arbitrarily rotated deserialized words, then decodes control/video symbols.
//
// Parameters
//   CTRL_RUN      : consecutive control tokens needed to declare lock
//   SEARCH_WINDOW : cycles spent at one bit offset before trying the next
//   LOCK_TIMEOUT  : cycles allowed in lock without a full token run
//
// Ports
//   clk_pixel  : in        pixel clock, the only clock
//   reset      : in        asynchronous, active-high reset
//   raw_word   : in  [9:0] deserialized word, bit 0 earliest, any rotation
//   de         : out       1 during a decoded video symbol
//   ctrl       : out [1:0] last decoded control code {c1,c0}
//   data       : out [7:0] decoded video byte
//   locked     : out       symbol alignment established
//   bit_offset : out [3:0] current alignment offset, 0..9
//
// Pipeline: raw_word -> r_prev -> r_aligned -> decoded outputs (3 edges).
// ----------------------------------------------------------------------------
module tmds_channel_rx
    import tmds_pkg::*;
#(
    parameter int CTRL_RUN      = 8,
    parameter int SEARCH_WINDOW = 2048,
    parameter int LOCK_TIMEOUT  = 4096
) (
    input  logic       clk_pixel,
    input  logic       reset,
    input  logic [9:0] raw_word,
    output logic       de,
    output logic [1:0] ctrl,
    output logic [7:0] data,
    output logic       locked,
    output logic [3:0] bit_offset
);

    localparam int RUN_W = $clog2(CTRL_RUN + 1);
    localparam int WIN_W = (SEARCH_WINDOW > 1) ? $clog2(SEARCH_WINDOW) : 1;
    localparam int TMO_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

    localparam logic [RUN_W-1:0] RUN_FULL = RUN_W'(CTRL_RUN);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(CTRL_RUN - 1);
    localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(SEARCH_WINDOW - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT - 1);

    logic [9:0]       r_prev;
    logic [9:0]       r_aligned;
    logic [19:0]      w_window;

    rx_state_t        r_state;
    rx_state_t        w_state_nxt;
    logic [RUN_W-1:0] r_run_cnt;
    logic [RUN_W-1:0] w_run_nxt;
    logic [WIN_W-1:0] r_window_cnt;
    logic [WIN_W-1:0] w_window_nxt;
    logic [TMO_W-1:0] r_timeout_cnt;
    logic [TMO_W-1:0] w_timeout_nxt;
    logic [3:0]       r_bit_offset;
    logic [3:0]       w_offset_nxt;

    logic             w_is_ctrl;
    logic [1:0]       w_ctrl;
    logic [7:0]       w_data;

    logic             r_de;
    logic [1:0]       r_ctrl;
    logic [7:0]       r_data;
    logic             r_locked;

    // ---- stage 1/2: previous word and aligned symbol ----
    // The window holds the older word in its low half, so offset k selects
    // the ten bits starting k bits into the older word.
    assign w_window = {raw_word, r_prev};

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            r_prev    <= 10'd0;
            r_aligned <= 10'd0;
        end else begin
            r_prev    <= raw_word;
            r_aligned <= w_window[r_bit_offset +: 10];
        end
    end

    tmds_symbol_decode u_decode (
        .aligned_word (r_aligned),
        .is_ctrl      (w_is_ctrl),
        .ctrl         (w_ctrl),
        .data         (w_data)
    );

    // Alignment FSM. Counters stop at their terminal value before they could
    // wrap, because reaching it always triggers a transition or a clear.
    always_comb begin
        w_state_nxt   = r_state;
        w_run_nxt     = r_run_cnt;
        w_window_nxt  = r_window_cnt;
        w_timeout_nxt = r_timeout_cnt;
        w_offset_nxt  = r_bit_offset;
        case (r_state)
            SEARCH: begin
                if (w_is_ctrl) begin
                    if (CTRL_RUN <= 1) begin
                        w_state_nxt   = LOCKED;
                        w_run_nxt     = RUN_FULL;
                        w_timeout_nxt = '0;
                    end else begin
                        w_state_nxt = VERIFY;
                        w_run_nxt   = RUN_ONE;
                    end
                end else if (r_window_cnt == WIN_LAST) begin
                    w_offset_nxt = (r_bit_offset == 4'd9) ? 4'd0 : r_bit_offset + 4'd1;
                    w_window_nxt = '0;
                end else begin
                    w_window_nxt = r_window_cnt + 1'b1;
                end
            end
            VERIFY: begin
                if (w_is_ctrl) begin
                    if (r_run_cnt >= RUN_LAST) begin
                        w_state_nxt   = LOCKED;
                        w_run_nxt     = RUN_FULL;
                        w_timeout_nxt = '0;
                    end else begin
                        w_run_nxt = r_run_cnt + 1'b1;
                    end
                end else begin
                    w_state_nxt  = SEARCH;
                    w_run_nxt    = '0;
                    w_window_nxt = '0;
                end
            end
            LOCKED: begin
                if (w_is_ctrl && (r_run_cnt >= RUN_LAST)) begin
                    // A complete token run (or any token extending one)
                    // refreshes the lock.
                    w_run_nxt     = RUN_FULL;
                    w_timeout_nxt = '0;
                end else begin
                    w_run_nxt = w_is_ctrl ? r_run_cnt + 1'b1 : '0;
                    if (r_timeout_cnt == TMO_LAST) begin
                        w_state_nxt   = SEARCH;
                        w_run_nxt     = '0;
                        w_window_nxt  = '0;
                        w_timeout_nxt = '0;
                    end else begin
                        w_timeout_nxt = r_timeout_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt   = SEARCH;
                w_run_nxt     = '0;
                w_window_nxt  = '0;
                w_timeout_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            r_state       <= SEARCH;
            r_run_cnt     <= '0;
            r_window_cnt  <= '0;
            r_timeout_cnt <= '0;
            r_bit_offset  <= 4'd0;
            r_locked      <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_run_cnt     <= w_run_nxt;
            r_window_cnt  <= w_window_nxt;
            r_timeout_cnt <= w_timeout_nxt;
            r_bit_offset  <= w_offset_nxt;
            r_locked      <= (w_state_nxt == LOCKED);
        end
    end

    // ---- stage 3: decoded outputs ----
    // Gated by the state being entered on this edge so outputs and locked
    // always change together; ctrl keeps the last code across video symbols.
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            r_de   <= 1'b0;
            r_ctrl <= 2'b00;
            r_data <= 8'd0;
        end else if (w_state_nxt != LOCKED) begin
            r_de   <= 1'b0;
            r_ctrl <= 2'b00;
            r_data <= 8'd0;
        end else if (w_is_ctrl) begin
            r_de   <= 1'b0;
            r_ctrl <= w_ctrl;
            r_data <= 8'd0;
        end else begin
            r_de   <= 1'b1;
            r_data <= w_data;
        end
    end

    assign de         = r_de;
    assign ctrl       = r_ctrl;
    assign data       = r_data;
    assign locked     = r_locked;
    assign bit_offset = r_bit_offset;

endmodule

// File: tb/tb_tmds_channel_rx.sv
module tb_tmds_channel_rx;

    logic       clk_pixel = 1'b0;
    logic       reset     = 1'b0;
    logic [9:0] raw_word  = 10'd0;
    logic       de;
    logic [1:0] ctrl;
    logic [7:0] data;
    logic       locked;
    logic [3:0] bit_offset;

    int checks = 0;
    int errors = 0;

    // Previous symbol of the serial stream, used to build rotated raw words.
    logic [9:0] prev_sym = 10'd0;

    tmds_channel_rx #(
        .CTRL_RUN      (8),
        .SEARCH_WINDOW (2048),
        .LOCK_TIMEOUT  (4096)
    ) dut (
        .clk_pixel  (clk_pixel),
        .reset      (reset),
        .raw_word   (raw_word),
        .de         (de),
        .ctrl       (ctrl),
        .data       (data),
        .locked     (locked),
        .bit_offset (bit_offset)
    );

    always #5 clk_pixel = ~clk_pixel;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [9:0] tok(input logic [1:0] c);
        case (c)
            2'b00:   return 10'b1101010100;
            2'b01:   return 10'b0010101011;
            2'b10:   return 10'b0101010100;
            default: return 10'b1010101011;
        endcase
    endfunction

    function automatic logic is_token(input logic [9:0] w);
        return (w == tok(2'b00)) || (w == tok(2'b01)) || (w == tok(2'b10)) || (w == tok(2'b11));
    endfunction

    // Transmit-side encoding: the decoder must recover d from this symbol.
    function automatic logic [9:0] encode(input logic [7:0] d, input logic q8, input logic inv);
        logic [7:0] q;
        q[0] = d[0];
        for (int i = 1; i < 8; i++) q[i] = q8 ? (q[i-1] ^ d[i]) : ~(q[i-1] ^ d[i]);
        return {inv, q8, inv ? ~q : q};
    endfunction

    task automatic rand_data(output logic [9:0] w, output logic [7:0] b);
        do begin
            b = 8'($urandom);
            w = encode(b, 1'($urandom), 1'($urandom));
        end while (is_token(w));
    endtask

    // Serial stream with symbol m at bits 10m+k .. 10m+k+9; raw word n is
    // bits 10n .. 10n+9 of that stream.
    task automatic send(input logic [9:0] sym, input int k);
        logic [19:0] tmp;
        tmp      = {sym, prev_sym} >> (10 - k);
        raw_word = tmp[9:0];
        prev_sym = sym;
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic apply_reset();
        reset    = 1'b1;
        prev_sym = tok(2'b00);
        raw_word = tok(2'b00);
        repeat (2) @(posedge clk_pixel);
        @(negedge clk_pixel);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({de, ctrl, data} !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs: got de=%b ctrl=%b data=%h, expected 0/00/00", de, ctrl, data);
        end
        checks++;
        if ({locked, bit_offset} !== 5'd0) begin
            errors++;
            $display("FAIL reset_lock: got locked=%b bit_offset=%0d, expected 0/0", locked, bit_offset);
        end
    endtask

    task automatic test_lock();
        apply_reset();
        for (int s = 1; s <= 16; s++) begin
            send(tok(2'b00), 0);
            if (s == 9) begin
                checks++;
                if (locked !== 1'b0) begin
                    errors++;
                    $display("FAIL lock_early: got locked=%b after 9 cycles, expected 0", locked);
                end
            end
            if (s == 10) begin
                checks++;
                if ({locked, de, ctrl, bit_offset} !== {1'b1, 1'b0, 2'b00, 4'd0}) begin
                    errors++;
                    $display("FAIL lock_at_10: got locked=%b de=%b ctrl=%b off=%0d, expected 1/0/00/0",
                             locked, de, ctrl, bit_offset);
                end
            end
        end
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL lock_hold: got locked=%b after 16 tokens, expected 1", locked);
        end
    endtask

    task automatic test_decode();
        logic [9:0]  syms[$];
        logic [10:0] exps[$];
        logic [1:0]  last_c;
        logic [1:0]  c;
        logic [9:0]  w;
        logic [7:0]  b;
        last_c = 2'b00;
        for (int p = 0; p < 3; p++) begin
            for (int m = 0; m < 4; m++) begin
                b = (p == 0) ? 8'h00 : (p == 1) ? 8'hFF : 8'hA5;
                w = encode(b, m[0], m[1]);
                if (!is_token(w)) begin
                    syms.push_back(w);
                    exps.push_back({1'b1, last_c, b});
                end
            end
        end
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(3) == 0) begin
                c      = 2'($urandom);
                last_c = c;
                syms.push_back(tok(c));
                exps.push_back({1'b0, c, 8'h00});
            end else begin
                rand_data(w, b);
                syms.push_back(w);
                exps.push_back({1'b1, last_c, b});
            end
        end
        for (int n = 0; n < syms.size() + 2; n++) begin
            send((n < syms.size()) ? syms[n] : tok(2'b00), 0);
            if (n >= 2) begin
                checks++;
                if ({de, ctrl, data} !== exps[n-2]) begin
                    errors++;
                    $display("FAIL decode[%0d]: got de=%b ctrl=%b data=%h, expected de=%b ctrl=%b data=%h",
                             n - 2, de, ctrl, data, exps[n-2][10], exps[n-2][9:8], exps[n-2][7:0]);
                end
            end
        end
    endtask

    task automatic test_abort();
        logic [9:0] s_sym;
        apply_reset();
        for (int s = 1; s <= 18; s++) begin
            s_sym = (s == 6) ? encode(8'hA5, 1'b1, 1'b0) : tok(2'b00);
            send(s_sym, 0);
            if (s <= 15) begin
                checks++;
                if (locked !== 1'b0) begin
                    errors++;
                    $display("FAIL abort_nolock[%0d]: got locked=%b, expected 0", s, locked);
                end
            end
            if (s == 16) begin
                checks++;
                if (locked !== 1'b1) begin
                    errors++;
                    $display("FAIL abort_relock: got locked=%b after second run, expected 1", locked);
                end
            end
        end
    endtask

    task automatic test_rotation_timeout();
        logic [9:0] w;
        logic [7:0] b;
        int         got_lock;
        apply_reset();
        got_lock = 0;
        for (int s = 1; s <= 8000 && got_lock == 0; s++) begin
            send(tok(2'b00), 3);
            if (s == 1000) begin
                checks++;
                if ({bit_offset, locked, de, ctrl, data} !== 16'd0) begin
                    errors++;
                    $display("FAIL rot_search0: got off=%0d locked=%b de=%b ctrl=%b data=%h, expected 0 all",
                             bit_offset, locked, de, ctrl, data);
                end
            end
            if (s == 3000 || s == 5000) begin
                checks++;
                if (bit_offset !== 4'((s == 3000) ? 1 : 2)) begin
                    errors++;
                    $display("FAIL rot_step@%0d: got off=%0d, expected %0d", s, bit_offset, (s == 3000) ? 1 : 2);
                end
            end
            if (locked === 1'b1) got_lock = 1;
        end
        checks++;
        if (got_lock == 0) begin
            errors++;
            $display("FAIL rot_lock: got no lock within 8000 cycles, expected lock at offset 3");
        end
        checks++;
        if ({bit_offset, ctrl} !== {4'd3, 2'b00}) begin
            errors++;
            $display("FAIL rot_offset: got off=%0d ctrl=%b, expected 3/00", bit_offset, ctrl);
        end
        for (int s = 0; s < 8; s++) send(tok(2'b00), 3);
        for (int s = 1; s <= 4110; s++) begin
            rand_data(w, b);
            send(w, 3);
            if (s == 4000) begin
                checks++;
                if ({locked, bit_offset} !== {1'b1, 4'd3}) begin
                    errors++;
                    $display("FAIL timeout_early: got locked=%b off=%0d, expected 1/3", locked, bit_offset);
                end
            end
            if (s == 4110) begin
                checks++;
                if ({locked, de, bit_offset} !== {1'b0, 1'b0, 4'd3}) begin
                    errors++;
                    $display("FAIL timeout_drop: got locked=%b de=%b off=%0d, expected 0/0/3",
                             locked, de, bit_offset);
                end
            end
        end
    endtask

    task automatic test_reset_midlock();
        logic [9:0] w;
        logic [7:0] b;
        apply_reset();
        for (int s = 0; s < 12; s++) send(tok(2'b11), 0);
        for (int s = 0; s < 3; s++) begin
            rand_data(w, b);
            send(w, 0);
        end
        checks++;
        if ({locked, de, ctrl} !== 4'b1111) begin
            errors++;
            $display("FAIL midlock_pre: got locked=%b de=%b ctrl=%b, expected 1/1/11", locked, de, ctrl);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({de, ctrl, data, locked, bit_offset} !== 16'd0) begin
            errors++;
            $display("FAIL midlock_reset: got de=%b ctrl=%b data=%h locked=%b off=%0d, expected all 0",
                     de, ctrl, data, locked, bit_offset);
        end
        @(posedge clk_pixel);
        @(negedge clk_pixel);
        reset    = 1'b0;
        prev_sym = tok(2'b00);
        for (int s = 1; s <= 12; s++) begin
            send(tok(2'b00), 0);
            if (s == 9 || s == 10) begin
                checks++;
                if (locked !== ((s == 10) ? 1'b1 : 1'b0)) begin
                    errors++;
                    $display("FAIL midlock_relock@%0d: got locked=%b, expected %b", s, locked, (s == 10));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_decode();
        test_abort();
        test_rotation_timeout();
        test_reset_midlock();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
